// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcodes, immediate format classes and small decode helpers for the
// registered immediate generator.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6,
        IMM_SH   = 3'd7
    } imm_type_e;

    // SLLI / SRLI / SRAI share these funct3 codes in both OP-IMM and OP-IMM-32.
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side request and decode-side result channels of the immediate generator.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    import imm_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_type_e        out_type;
    logic             out_illeg;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illeg, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illeg, out_tag
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Pure combinational RISC-V immediate decode: instruction word -> immediate,
// format class and illegal flag, for RV32 or RV64.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       typ,
    output logic            illeg
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [5:0]      shamt6;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_sh32;
    logic [XLEN-1:0] imm_zimm;
    logic [XLEN-1:0] imm_csr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // RV32 only has a 5-bit shift amount; bit 25 is then only used to flag illegal.
    assign shamt6 = IS_RV64 ? instr[25:20] : {1'b0, instr[24:20]};

    assign imm_i    = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
    assign imm_j    = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
    assign imm_sh   = {{(XLEN-6){1'b0}}, shamt6};
    assign imm_sh32 = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign imm_zimm = {{(XLEN-5){1'b0}}, instr[19:15]};
    assign imm_csr  = {{(XLEN-12){1'b0}}, instr[31:20]};

    generate
        if (IS_RV64) begin : g_u_rv64
            assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
        end else begin : g_u_rv32
            assign imm_u = {instr[31:12], 12'b0};
        end
    endgenerate

    always_comb begin
        imm   = '0;
        typ   = IMM_NONE;
        illeg = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illeg = 1'b1;
        end else begin
            case (opcode)
                OPC_OP, OPC_OP32: begin
                    imm = '0;
                    typ = IMM_NONE;
                end
                OPC_LOAD, OPC_JALR: begin
                    imm = imm_i;
                    typ = IMM_I;
                end
                OPC_OPIMM: begin
                    if (is_shift_f3(funct3)) begin
                        imm   = imm_sh;
                        typ   = IMM_SH;
                        illeg = !IS_RV64 && instr[25];
                    end else begin
                        imm = imm_i;
                        typ = IMM_I;
                    end
                end
                OPC_OPIMM32: begin
                    // Word ops still report their immediate; RV32 just marks them illegal.
                    if (is_shift_f3(funct3)) begin
                        imm = imm_sh32;
                        typ = IMM_SH;
                    end else begin
                        imm = imm_i;
                        typ = IMM_I;
                    end
                    illeg = !IS_RV64;
                end
                OPC_STORE: begin
                    imm = imm_s;
                    typ = IMM_S;
                end
                OPC_BRANCH: begin
                    imm = imm_b;
                    typ = IMM_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm = imm_u;
                    typ = IMM_U;
                end
                OPC_JAL: begin
                    imm = imm_j;
                    typ = IMM_J;
                end
                OPC_SYSTEM: begin
                    imm = funct3[2] ? imm_zimm : imm_csr;
                    typ = IMM_Z;
                end
                default: begin
                    illeg = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, flow-controlled immediate generator: one output register plus one
// skid entry, so in_ready is a flop and never depends on out_ready in the same cycle.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("imm_gen_pipe: TAG_W must be at least 1");
        end
    endgenerate

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illeg;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr (bus.in_instr),
        .imm   (dec_imm),
        .typ   (dec_type),
        .illeg (dec_illeg)
    );

    logic             out_valid_reg,  out_valid_next;
    logic [XLEN-1:0]  out_imm_reg,    out_imm_next;
    imm_type_e        out_type_reg,   out_type_next;
    logic             out_illeg_reg,  out_illeg_next;
    logic [TAG_W-1:0] out_tag_reg,    out_tag_next;

    logic             skid_valid_reg, skid_valid_next;
    logic [XLEN-1:0]  skid_imm_reg,   skid_imm_next;
    imm_type_e        skid_type_reg,  skid_type_next;
    logic             skid_illeg_reg, skid_illeg_next;
    logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;

    logic             in_ready_reg,   in_ready_next;

    logic accept;
    logic out_free;

    assign accept   = bus.in_valid && in_ready_reg;
    assign out_free = !out_valid_reg || bus.out_ready;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_imm_next    = out_imm_reg;
        out_type_next   = out_type_reg;
        out_illeg_next  = out_illeg_reg;
        out_tag_next    = out_tag_reg;
        skid_valid_next = skid_valid_reg;
        skid_imm_next   = skid_imm_reg;
        skid_type_next  = skid_type_reg;
        skid_illeg_next = skid_illeg_reg;
        skid_tag_next   = skid_tag_reg;

        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_free) begin
            // The skid entry is older than anything offered now, so it goes first;
            // in_ready is low while it is occupied, so no accept can collide with it.
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_imm_next    = skid_imm_reg;
                out_type_next   = skid_type_reg;
                out_illeg_next  = skid_illeg_reg;
                out_tag_next    = skid_tag_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_valid_next  = 1'b1;
                out_imm_next    = dec_imm;
                out_type_next   = dec_type;
                out_illeg_next  = dec_illeg;
                out_tag_next    = bus.in_tag;
            end else begin
                out_valid_next  = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_imm_next   = dec_imm;
            skid_type_next  = dec_type;
            skid_illeg_next = dec_illeg;
            skid_tag_next   = bus.in_tag;
        end

        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_imm_reg    <= '0;
            out_type_reg   <= IMM_NONE;
            out_illeg_reg  <= 1'b0;
            out_tag_reg    <= '0;
            skid_valid_reg <= 1'b0;
            skid_imm_reg   <= '0;
            skid_type_reg  <= IMM_NONE;
            skid_illeg_reg <= 1'b0;
            skid_tag_reg   <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_imm_reg    <= out_imm_next;
            out_type_reg   <= out_type_next;
            out_illeg_reg  <= out_illeg_next;
            out_tag_reg    <= out_tag_next;
            skid_valid_reg <= skid_valid_next;
            skid_imm_reg   <= skid_imm_next;
            skid_type_reg  <= skid_type_next;
            skid_illeg_reg <= skid_illeg_next;
            skid_tag_reg   <= skid_tag_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_imm   = out_imm_reg;
    assign bus.out_type  = out_type_reg;
    assign bus.out_illeg = out_illeg_reg;
    assign bus.out_tag   = out_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 and an RV64 instance share one stimulus stream;
// each has its own reference decode and in-order scoreboard.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus64.slave)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        illeg;
        logic [31:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic longint sext(input longint val, input int w);
        longint half;
        half = longint'(1) <<< (w - 1);
        return (val >= half) ? (val - 2 * half) : val;
    endfunction

    // Field extraction with plain arithmetic on the instruction value.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] tag,
                                        input int xlen);
        exp_t   e;
        longint u;
        longint v;
        int     f3;
        u       = longint'({32'b0, instr});
        v       = 0;
        f3      = int'(instr[14:12]);
        e.typ   = IMM_NONE;
        e.illeg = 1'b0;
        e.tag   = tag;
        if (instr[1:0] != 2'b11) begin
            e.illeg = 1'b1;
        end else begin
            case (instr[6:0])
                OPC_OP, OPC_OP32: v = 0;
                OPC_LOAD, OPC_JALR: begin
                    v = sext(u >> 20, 12);
                    e.typ = IMM_I;
                end
                OPC_OPIMM, OPC_OPIMM32: begin
                    if (f3 == 1 || f3 == 5) begin
                        if (instr[6:0] == OPC_OPIMM && xlen == 64) v = (u >> 20) % 64;
                        else v = (u >> 20) % 32;
                        e.typ = IMM_SH;
                        if (instr[6:0] == OPC_OPIMM && xlen == 32 && ((u >> 25) % 2) == 1)
                            e.illeg = 1'b1;
                    end else begin
                        v = sext(u >> 20, 12);
                        e.typ = IMM_I;
                    end
                    if (instr[6:0] == OPC_OPIMM32 && xlen == 32) e.illeg = 1'b1;
                end
                OPC_STORE: begin
                    v = sext((u >> 25) * 32 + (u >> 7) % 32, 12);
                    e.typ = IMM_S;
                end
                OPC_BRANCH: begin
                    v = sext(((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
                             + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2, 13);
                    e.typ = IMM_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    v = sext((u >> 12) * 4096, 32);
                    e.typ = IMM_U;
                end
                OPC_JAL: begin
                    v = sext(((u >> 31) % 2) * 1048576 + ((u >> 12) % 256) * 4096
                             + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2, 21);
                    e.typ = IMM_J;
                end
                OPC_SYSTEM: begin
                    v = (f3 >= 4) ? (u >> 15) % 32 : (u >> 20);
                    e.typ = IMM_Z;
                end
                default: e.illeg = 1'b1;
            endcase
        end
        e.imm = (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [12];
        opcs = '{OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_AUIPC, OPC_STORE, OPC_OP,
                 OPC_LUI, OPC_OP32, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            w[6:0] = opcs[$urandom_range(0, 11)];
            if ((w[6:0] == OPC_OPIMM || w[6:0] == OPC_OPIMM32) && $urandom_range(0, 1) == 1)
                w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
        end
        return w;
    endfunction

    // Scoreboards: depth of the queue is the number of beats the DUT must be holding.
    always @(negedge clk) begin : mon32
        int   depth;
        exp_t e;
        if (rst) begin
            q32.delete();
        end else if (mon_en) begin
            depth = q32.size();
            check("d32 out_valid", 64'(bus32.out_valid), 64'(depth > 0));
            check("d32 in_ready", 64'(bus32.in_ready), 64'(depth < 2));
            if (flush) begin
                q32.delete();
            end else begin
                if (out_ready && depth > 0) begin
                    e = q32.pop_front();
                    $display("[TB] d32 out tag=%h imm=%h type=%0d illeg=%0b",
                             bus32.out_tag, bus32.out_imm, bus32.out_type, bus32.out_illeg);
                    check("d32 imm", 64'(bus32.out_imm), e.imm);
                    check("d32 type", 64'(bus32.out_type), 64'(e.typ));
                    check("d32 illeg", 64'(bus32.out_illeg), 64'(e.illeg));
                    check("d32 tag", 64'(bus32.out_tag), 64'(e.tag));
                end
                if (in_valid && depth < 2) q32.push_back(ref_decode(in_instr, in_tag, 32));
            end
        end
    end

    always @(negedge clk) begin : mon64
        int   depth;
        exp_t e;
        if (rst) begin
            q64.delete();
        end else if (mon_en) begin
            depth = q64.size();
            check("d64 out_valid", 64'(bus64.out_valid), 64'(depth > 0));
            check("d64 in_ready", 64'(bus64.in_ready), 64'(depth < 2));
            if (flush) begin
                q64.delete();
            end else begin
                if (out_ready && depth > 0) begin
                    e = q64.pop_front();
                    $display("[TB] d64 out tag=%h imm=%h type=%0d illeg=%0b",
                             bus64.out_tag, bus64.out_imm, bus64.out_type, bus64.out_illeg);
                    check("d64 imm", bus64.out_imm, e.imm);
                    check("d64 type", 64'(bus64.out_type), 64'(e.typ));
                    check("d64 illeg", 64'(bus64.out_illeg), 64'(e.illeg));
                    check("d64 tag", 64'(bus64.out_tag), 64'(e.tag));
                end
                if (in_valid && depth < 2) q64.push_back(ref_decode(in_instr, in_tag, 64));
            end
        end
    end

    task automatic check_reset_state(input string name);
        check({name, " d32 out_valid"}, 64'(bus32.out_valid), 64'd0);
        check({name, " d32 out_imm"},   64'(bus32.out_imm),   64'd0);
        check({name, " d32 out_type"},  64'(bus32.out_type),  64'(IMM_NONE));
        check({name, " d32 out_illeg"}, 64'(bus32.out_illeg), 64'd0);
        check({name, " d32 out_tag"},   64'(bus32.out_tag),   64'd0);
        check({name, " d32 in_ready"},  64'(bus32.in_ready),  64'd1);
        check({name, " d64 out_valid"}, 64'(bus64.out_valid), 64'd0);
        check({name, " d64 out_imm"},   bus64.out_imm,        64'd0);
        check({name, " d64 out_type"},  64'(bus64.out_type),  64'(IMM_NONE));
        check({name, " d64 out_illeg"}, 64'(bus64.out_illeg), 64'd0);
        check({name, " d64 out_tag"},   64'(bus64.out_tag),   64'd0);
        check({name, " d64 in_ready"},  64'(bus64.in_ready),  64'd1);
    endtask

    task automatic drive_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = rand_instr();
            in_tag    = $urandom;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    logic [31:0] dir_instr [6];
    logic [31:0] dir_imm32 [6];
    logic [63:0] dir_imm64 [6];
    logic [2:0]  dir_type  [6];
    logic        dir_ill32 [6];

    initial begin
        dir_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123452B7,
                      32'h800002B7, 32'h03F09093};
        dir_imm32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                      32'h80000000, 32'h0000001F};
        dir_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                      64'h0000000012345000, 64'hFFFFFFFF80000000, 64'h000000000000003F};
        dir_type  = '{IMM_I, IMM_S, IMM_B, IMM_U, IMM_U, IMM_SH};
        dir_ill32 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = 32'h0;
        in_tag    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(posedge clk);
        #3;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // Directed words streamed back to back; each result one cycle after its beat.
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk);
            #1;
            if (i < 6) begin
                in_valid = 1'b1;
                in_instr = dir_instr[i];
                in_tag   = 32'h100 + i;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                check("dir d32 valid", 64'(bus32.out_valid), 64'd1);
                check("dir d32 imm",   64'(bus32.out_imm),   64'(dir_imm32[i-1]));
                check("dir d32 type",  64'(bus32.out_type),  64'(dir_type[i-1]));
                check("dir d32 illeg", 64'(bus32.out_illeg), 64'(dir_ill32[i-1]));
                check("dir d32 tag",   64'(bus32.out_tag),   64'(32'h100 + i - 1));
                check("dir d32 ready", 64'(bus32.in_ready),  64'd1);
                check("dir d64 imm",   bus64.out_imm,        dir_imm64[i-1]);
                check("dir d64 type",  64'(bus64.out_type),  64'(dir_type[i-1]));
                check("dir d64 illeg", 64'(bus64.out_illeg), 64'd0);
            end
        end

        // Stall with streaming input: output + skid fill, in_ready drops.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_instr  = rand_instr();
            in_tag    = $urandom;
        end
        @(negedge clk);
        check("stall d32 in_ready",  64'(bus32.in_ready),  64'd0);
        check("stall d32 out_valid", 64'(bus32.out_valid), 64'd1);
        check("stall d64 in_ready",  64'(bus64.in_ready),  64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_instr  = rand_instr();
            in_tag    = $urandom;
            @(negedge clk);
            check("release d32 no bubble", 64'(bus32.out_valid), 64'd1);
            check("release d64 no bubble", 64'(bus64.out_valid), 64'd1);
        end

        // Flush with both entries full and a beat offered.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_instr  = rand_instr();
            in_tag    = $urandom;
        end
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        in_tag   = 32'hDEAD;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush d32 out_valid", 64'(bus32.out_valid), 64'd0);
        check("flush d32 in_ready",  64'(bus32.in_ready),  64'd1);
        check("flush d64 out_valid", 64'(bus64.out_valid), 64'd0);
        check("flush d64 in_ready",  64'(bus64.in_ready),  64'd1);

        drive_random(1500);

        // Asynchronous reset in the middle of a stall.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_instr  = rand_instr();
            in_tag    = $urandom;
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("async rst");
        repeat (2) @(posedge clk);
        #3;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        in_tag   = 32'h0ABC;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-rst d32 valid", 64'(bus32.out_valid), 64'd1);
        check("post-rst d32 imm",   64'(bus32.out_imm),   64'hFFFFFFFF);
        check("post-rst d32 tag",   64'(bus32.out_tag),   64'h0ABC);
        check("post-rst d64 imm",   bus64.out_imm,        64'hFFFFFFFFFFFFFFFF);

        drive_random(300);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
